// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared types and default widths for the CDB arbiter and its result FIFOs.
//   No ports. Defaults mirror the processor-wide ROB position and data widths.
package cdb_arbiter_pkg;

  localparam int CDB_Q_DEPTH = 4;
  localparam int CDB_POS_W   = 4;
  localparam int CDB_DATA_W  = 32;

  // CDB source encoding: 0 = ALU, 1 = LSB
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo
//   Per-source result queue in front of the CDB scheduler.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     flush           synchronous flush (mispredict rollback), same effect as rst
//     push, push_data enqueue at tail; caller only pushes when !full
//     pop             dequeue head; caller only pops when !empty
//     full, empty     combinational occupancy flags
//     head_data       entry at the head (undefined content while empty)
module cdb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_ONE;
      if (pop)  head_q <= head_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Storage is not reset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the common data bus between the ALU and the load/store buffer.
//   Each producer pushes into its own result FIFO; a round-robin scheduler
//   drives at most one registered result per cycle onto the CDB.
//   Optional macro CDB_BYPASS_EN: when both queues are empty, a push goes
//   straight to the CDB registers (1-cycle latency) instead of the queue.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     rdy                   global enable; low holds all state, drops pushes
//     rollback              synchronous flush of queues and CDB registers
//     alu_result*/lsb_result*  push strobes, ROB positions and values
//     alu_q_full/lsb_q_full combinational queue-full flags
//     cdb_valid/rob_pos/val/src  registered CDB broadcast
//     err_overflow          sticky push-while-full flag, cleared only by rst
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int Q_DEPTH = CDB_Q_DEPTH,
  parameter int POS_W   = CDB_POS_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              alu_result,
  input  logic [POS_W-1:0]  alu_result_rob_pos,
  input  logic [DATA_W-1:0] alu_result_val,
  input  logic              lsb_result,
  input  logic [POS_W-1:0]  lsb_result_rob_pos,
  input  logic [DATA_W-1:0] lsb_result_val,
  output logic              alu_q_full,
  output logic              lsb_q_full,
  output logic              cdb_valid,
  output logic [POS_W-1:0]  cdb_rob_pos,
  output logic [DATA_W-1:0] cdb_val,
  output logic              cdb_src,
  output logic              err_overflow
);

  localparam int ENT_W = POS_W + DATA_W;

  logic             alu_full, alu_empty, lsb_full, lsb_empty;
  logic [ENT_W-1:0] alu_head, lsb_head;
  logic             alu_push_ok, lsb_push_ok;
  logic             alu_enq, lsb_enq;
  logic             grant_alu, grant_lsb;
  logic             byp_alu, byp_lsb;

  cdb_src_e          last_grant_q, last_grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [POS_W-1:0]  cdb_pos_q, cdb_pos_d;
  logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
  cdb_src_e          cdb_src_q, cdb_src_d;
  logic              err_q, err_d;

  assign alu_push_ok = rdy && alu_result && !alu_full;
  assign lsb_push_ok = rdy && lsb_result && !lsb_full;

  // Scheduler works only on entries already queued at this edge.
  assign grant_alu = rdy && !alu_empty && (lsb_empty || last_grant_q == SRC_LSB);
  assign grant_lsb = rdy && !lsb_empty && !grant_alu;

`ifdef CDB_BYPASS_EN
  // Bypass only with both queues empty; a tie is settled like a normal grant.
  assign byp_alu = alu_empty && lsb_empty && alu_push_ok &&
                   (!lsb_push_ok || last_grant_q == SRC_LSB);
  assign byp_lsb = alu_empty && lsb_empty && lsb_push_ok && !byp_alu;
`else
  assign byp_alu = 1'b0;
  assign byp_lsb = 1'b0;
`endif

  assign alu_enq = alu_push_ok && !byp_alu;
  assign lsb_enq = lsb_push_ok && !byp_lsb;

  cdb_result_fifo #(.DEPTH(Q_DEPTH), .WIDTH(ENT_W)) u_alu_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (rollback),
    .push      (alu_enq),
    .push_data ({alu_result_rob_pos, alu_result_val}),
    .pop       (grant_alu),
    .full      (alu_full),
    .empty     (alu_empty),
    .head_data (alu_head)
  );

  cdb_result_fifo #(.DEPTH(Q_DEPTH), .WIDTH(ENT_W)) u_lsb_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (rollback),
    .push      (lsb_enq),
    .push_data ({lsb_result_rob_pos, lsb_result_val}),
    .pop       (grant_lsb),
    .full      (lsb_full),
    .empty     (lsb_empty),
    .head_data (lsb_head)
  );

  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_pos_d    = cdb_pos_q;
    cdb_val_d    = cdb_val_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (byp_alu) begin
      cdb_valid_d  = 1'b1;
      cdb_pos_d    = alu_result_rob_pos;
      cdb_val_d    = alu_result_val;
      cdb_src_d    = SRC_ALU;
      last_grant_d = SRC_ALU;
    end else if (byp_lsb) begin
      cdb_valid_d  = 1'b1;
      cdb_pos_d    = lsb_result_rob_pos;
      cdb_val_d    = lsb_result_val;
      cdb_src_d    = SRC_LSB;
      last_grant_d = SRC_LSB;
    end else if (grant_alu) begin
      cdb_valid_d  = 1'b1;
      {cdb_pos_d, cdb_val_d} = alu_head;
      cdb_src_d    = SRC_ALU;
      last_grant_d = SRC_ALU;
    end else if (grant_lsb) begin
      cdb_valid_d  = 1'b1;
      {cdb_pos_d, cdb_val_d} = lsb_head;
      cdb_src_d    = SRC_LSB;
      last_grant_d = SRC_LSB;
    end else if (rdy) begin
      cdb_valid_d  = 1'b0;   // idle cycle: payload keeps its last value
    end
  end

  // Drops under !rdy are silent; only an enabled push into a full queue counts.
  assign err_d = err_q || (rdy && ((alu_result && alu_full) || (lsb_result && lsb_full)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_pos_q    <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= SRC_ALU;
      last_grant_q <= SRC_LSB;
      err_q        <= 1'b0;
    end else if (rollback) begin
      cdb_valid_q  <= 1'b0;
      cdb_pos_q    <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= SRC_ALU;
      last_grant_q <= SRC_LSB;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_pos_q    <= cdb_pos_d;
      cdb_val_q    <= cdb_val_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign alu_q_full   = alu_full;
  assign lsb_q_full   = lsb_full;
  assign cdb_valid    = cdb_valid_q;
  assign cdb_rob_pos  = cdb_pos_q;
  assign cdb_val      = cdb_val_q;
  assign cdb_src      = cdb_src_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter in its default (queued, 2-cycle) build.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic        alu_q_full, lsb_q_full;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;
  logic        cdb_src;
  logic        err_overflow;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.Q_DEPTH(4), .POS_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val),
    .alu_q_full(alu_q_full), .lsb_q_full(lsb_q_full),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .cdb_src(cdb_src), .err_overflow(err_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_result = 0; lsb_result = 0;
    alu_result_rob_pos = 0; lsb_result_rob_pos = 0;
    alu_result_val = 0; lsb_result_val = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; rdy = 1; rollback = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (cdb_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", cdb_valid); else n_pass++;
    n_total++; if (cdb_rob_pos !== 4'd0 || cdb_val !== 32'd0 || cdb_src !== 1'b0)
      $display("FAIL reset_payload got pos=%0d val=%h src=%0b want 0/0/0", cdb_rob_pos, cdb_val, cdb_src); else n_pass++;
    n_total++; if (alu_q_full !== 1'b0 || lsb_q_full !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL reset_flags got af=%0b lf=%0b err=%0b want 0/0/0", alu_q_full, lsb_q_full, err_overflow); else n_pass++;
  endtask

  task automatic test_single_alu();
    alu_result = 1; alu_result_rob_pos = 4'd3; alu_result_val = 32'h11;
    step();                       // E0: enqueue
    idle_inputs();
    n_total++; if (cdb_valid !== 1'b0) $display("FAIL single_latency got valid=%0b want 0 after E0", cdb_valid); else n_pass++;
    step();                       // E1: grant
    n_total++; if (cdb_valid !== 1'b1 || cdb_rob_pos !== 4'd3 || cdb_val !== 32'h11 || cdb_src !== 1'b0)
      $display("FAIL single_result got v=%0b pos=%0d val=%h src=%0b want 1/3/11/0", cdb_valid, cdb_rob_pos, cdb_val, cdb_src); else n_pass++;
    step();
    n_total++; if (cdb_valid !== 1'b0 || cdb_rob_pos !== 4'd3)
      $display("FAIL single_after got v=%0b pos=%0d want 0/3", cdb_valid, cdb_rob_pos); else n_pass++;
  endtask

  task automatic test_alternation();
    logic [3:0] exp_pos [12];
    logic       exp_src [12];
    int n = 0;
    for (int i = 0; i < 6; i++) begin
      exp_pos[2*i] = 4'(i);     exp_src[2*i] = 1'b0;
      exp_pos[2*i+1] = 4'(8+i); exp_src[2*i+1] = 1'b1;
    end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c < 6) begin
        alu_result = 1; alu_result_rob_pos = 4'(c);   alu_result_val = 32'(c);
        lsb_result = 1; lsb_result_rob_pos = 4'(8+c); lsb_result_val = 32'(100+c);
      end else idle_inputs();
      step();
      if (cdb_valid === 1'b1) begin
        n_total++;
        if (n >= 12) $display("FAIL alt_extra got pos=%0d want no more results", cdb_rob_pos);
        else if (cdb_rob_pos !== exp_pos[n] || cdb_src !== exp_src[n])
          $display("FAIL alt_order[%0d] got pos=%0d src=%0b want %0d/%0b", n, cdb_rob_pos, cdb_src, exp_pos[n], exp_src[n]);
        else n_pass++;
        n++;
      end
    end
    n_total++; if (n !== 12) $display("FAIL alt_count got %0d want 12", n); else n_pass++;
    n_total++; if (err_overflow !== 1'b0) $display("FAIL alt_err got %0b want 0", err_overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      alu_result = 1; alu_result_rob_pos = 4'(k);   alu_result_val = 32'(k);
      lsb_result = 1; lsb_result_rob_pos = 4'(8+k); lsb_result_val = 32'(k);
      step();
      if (k == 4) begin
        n_total++; if (lsb_q_full !== 1'b0) $display("FAIL ovf_full3 got %0b want 0", lsb_q_full); else n_pass++;
      end
    end
    n_total++; if (lsb_q_full !== 1'b1 || alu_q_full !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL ovf_full4 got lf=%0b af=%0b err=%0b want 1/0/0", lsb_q_full, alu_q_full, err_overflow); else n_pass++;
    step();   // 7th push each: ALU accepted, LSB dropped while LSB is granted
    idle_inputs();
    n_total++; if (err_overflow !== 1'b1 || alu_q_full !== 1'b1 || lsb_q_full !== 1'b0 || cdb_src !== 1'b1)
      $display("FAIL ovf_drop got err=%0b af=%0b lf=%0b src=%0b want 1/1/0/1", err_overflow, alu_q_full, lsb_q_full, cdb_src); else n_pass++;
    step();
    rollback = 1;
    step();
    rollback = 0;
    n_total++; if (err_overflow !== 1'b1 || alu_q_full !== 1'b0 || cdb_valid !== 1'b0)
      $display("FAIL ovf_rollback got err=%0b af=%0b v=%0b want 1/0/0", err_overflow, alu_q_full, cdb_valid); else n_pass++;
    rst = 1;
    step();
    rst = 0;
    n_total++; if (err_overflow !== 1'b0) $display("FAIL ovf_rst got %0b want 0", err_overflow); else n_pass++;
  endtask

  task automatic test_rollback();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      alu_result = 1; alu_result_rob_pos = 4'(k);   alu_result_val = 32'(k);
      lsb_result = 1; lsb_result_rob_pos = 4'(8+k); lsb_result_val = 32'(k);
      step();
    end
    idle_inputs();
    n_total++; if (alu_q_full !== 1'b0 || lsb_q_full !== 1'b0 || cdb_valid !== 1'b1)
      $display("FAIL rb_pre got af=%0b lf=%0b v=%0b want 0/0/1", alu_q_full, lsb_q_full, cdb_valid); else n_pass++;
    rollback = 1; alu_result = 1; alu_result_rob_pos = 4'd15; alu_result_val = 32'hdead;
    step();
    rollback = 0; idle_inputs();
    n_total++; if (cdb_valid !== 1'b0 || cdb_rob_pos !== 4'd0 || alu_q_full !== 1'b0 || lsb_q_full !== 1'b0)
      $display("FAIL rb_flush got v=%0b pos=%0d af=%0b lf=%0b want 0/0/0/0", cdb_valid, cdb_rob_pos, alu_q_full, lsb_q_full); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++; if (cdb_valid !== 1'b0) $display("FAIL rb_quiet[%0d] got v=%0b pos=%0d want 0", k, cdb_valid, cdb_rob_pos); else n_pass++;
    end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    alu_result = 1; alu_result_rob_pos = 4'd6; alu_result_val = 32'h66;
    step();
    idle_inputs();
    step();
    rdy = 0;
    alu_result = 1; alu_result_rob_pos = 4'd9;  alu_result_val = 32'h99;
    lsb_result = 1; lsb_result_rob_pos = 4'd10; lsb_result_val = 32'haa;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++; if (cdb_valid !== 1'b1 || cdb_rob_pos !== 4'd6 || cdb_val !== 32'h66)
        $display("FAIL hold[%0d] got v=%0b pos=%0d val=%h want 1/6/66", k, cdb_valid, cdb_rob_pos, cdb_val); else n_pass++;
    end
    rdy = 1; idle_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++; if (cdb_valid !== 1'b0) $display("FAIL hold_drop[%0d] got v=%0b pos=%0d want 0", k, cdb_valid, cdb_rob_pos); else n_pass++;
    end
    n_total++; if (err_overflow !== 1'b0) $display("FAIL hold_err got %0b want 0", err_overflow); else n_pass++;
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (c < 12) begin
        alu_result = 1; alu_result_rob_pos = 4'(c); alu_result_val = 32'(3*c + 1);
      end else idle_inputs();
      step();
      if (cdb_valid === 1'b1) begin
        n_total++;
        if (n >= 12) $display("FAIL wrap_extra got pos=%0d want none", cdb_rob_pos);
        else if (cdb_rob_pos !== 4'(n) || cdb_val !== 32'(3*n + 1) || cdb_src !== 1'b0)
          $display("FAIL wrap[%0d] got pos=%0d val=%0d src=%0b want %0d/%0d/0", n, cdb_rob_pos, cdb_val, cdb_src, n, 3*n + 1);
        else n_pass++;
        n++;
      end
    end
    n_total++; if (n !== 12) $display("FAIL wrap_count got %0d want 12", n); else n_pass++;
    n_total++; if (err_overflow !== 1'b0) $display("FAIL wrap_err got %0b want 0", err_overflow); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    rst = 1; rdy = 1; rollback = 0;
    test_reset();
    test_single_alu();
    test_alternation();
    test_overflow();
    test_rollback();
    test_rdy_hold();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
